// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control slice.
// Holds the sequencer state encoding and the canonical NOP used for bubbles.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd2
    } pctl_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count up on inc, stop at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: per-stage enables, bubble
// controls, dmem wait timeout and saturating stall/flush counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_stall,
    input  logic             redirect,
    input  logic             imem_ready,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             en_F,
    output logic             en_D,
    output logic             en_E,
    output logic             en_M,
    output logic             en_W,
    output logic             flush_D,
    output logic             flush_E,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    pctl_state_t    state_r;
    logic           redir_pend_r;
    logic [WCW-1:0] wait_cnt_r;
    logic           mem_err_r;
    logic           dwait_s;
    logic           flush_inc_s;
    logic           stall_inc_s;

    assign dwait_s = dmem_req_M & ~dmem_ready;

    // Priority decode of enables and bubbles; a frozen stage never sees a flush.
    always_comb begin
        en_F        = 1'b0;
        en_D        = 1'b0;
        en_E        = 1'b0;
        en_M        = 1'b0;
        en_W        = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_inc_s = 1'b0;
        if (rst) begin
            en_F = 1'b0;
        end else if (state_r == ERR) begin
            en_F = 1'b0;
        end else if (dwait_s) begin
            en_F = 1'b0;
        end else if (redirect || redir_pend_r) begin
            en_F        = 1'b1;
            en_D        = 1'b1;
            en_E        = 1'b1;
            en_M        = 1'b1;
            en_W        = 1'b1;
            flush_D     = 1'b1;
            flush_E     = 1'b1;
            flush_inc_s = 1'b1;
        end else if (ld_stall) begin
            en_E    = 1'b1;
            en_M    = 1'b1;
            en_W    = 1'b1;
            flush_E = 1'b1;
        end else if (!imem_ready) begin
            en_D    = 1'b1;
            en_E    = 1'b1;
            en_M    = 1'b1;
            en_W    = 1'b1;
            flush_D = 1'b1;
        end else begin
            en_F = 1'b1;
            en_D = 1'b1;
            en_E = 1'b1;
            en_M = 1'b1;
            en_W = 1'b1;
        end
    end

    // Sequencer state, dmem wait length and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= {WCW{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (dwait_s) begin
                        state_r    <= DWAIT;
                        wait_cnt_r <= WCW'(1);
                    end
                end
                DWAIT: begin
                    if (dwait_s) begin
                        if (wait_cnt_r == WAIT_LAST) begin
                            state_r   <= ERR;
                            mem_err_r <= 1'b1;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + WCW'(1);
                        end
                    end else begin
                        // Covers both completion and a dropped request.
                        state_r    <= RUN;
                        wait_cnt_r <= {WCW{1'b0}};
                    end
                end
                ERR: begin
                    state_r <= ERR;
                end
                default: begin
                    state_r   <= ERR;
                    mem_err_r <= 1'b1;
                end
            endcase
        end
    end

    // Remember a redirect that arrived while frozen; one flag, not a count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_pend_r <= 1'b0;
        end else if ((state_r != ERR) && dwait_s && redirect) begin
            redir_pend_r <= 1'b1;
        end else if (flush_inc_s) begin
            redir_pend_r <= 1'b0;
        end
    end

    assign mem_err     = mem_err_r;
    assign stall_inc_s = ~en_F;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural model queues the expected
// controls/counters per cycle, which are popped and compared on the falling edge.
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT = 6;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = 15;

    logic             clk;
    logic             rst;
    logic             ld_stall;
    logic             redirect;
    logic             imem_ready;
    logic             dmem_req_M;
    logic             dmem_ready;
    logic             en_F;
    logic             en_D;
    logic             en_E;
    logic             en_M;
    logic             en_W;
    logic             flush_D;
    logic             flush_E;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    typedef struct {
        logic [7:0] ctl;
        int         scnt;
        int         fcnt;
        string      tag;
    } exp_t;

    exp_t sb[$];

    int n_checks   = 0;
    int n_failures = 0;

    // model state
    bit m_err;
    bit m_pend;
    int m_run;
    int m_scnt;
    int m_fcnt;

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_stall   (ld_stall),
        .redirect   (redirect),
        .imem_ready (imem_ready),
        .dmem_req_M (dmem_req_M),
        .dmem_ready (dmem_ready),
        .en_F       (en_F),
        .en_D       (en_D),
        .en_E       (en_E),
        .en_M       (en_M),
        .en_W       (en_W),
        .flush_D    (flush_D),
        .flush_E    (flush_E),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_reset();
        m_err  = 1'b0;
        m_pend = 1'b0;
        m_run  = 0;
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    // One clock of stimulus: predict, push, compare on negedge, advance model.
    task automatic cycle(input string tag, input logic ls, input logic rd, input logic im,
                         input logic rq, input logic rdy);
        exp_t e;
        exp_t g;
        bit   dw;
        bit   do_flush;
        ld_stall   = ls;
        redirect   = rd;
        imem_ready = im;
        dmem_req_M = rq;
        dmem_ready = rdy;
        dw       = rq & ~rdy;
        do_flush = 1'b0;
        // ctl = {en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, mem_err}
        if (rst)              e.ctl = 8'b0000_0000;
        else if (m_err)       e.ctl = 8'b0000_0001;
        else if (dw)          e.ctl = 8'b0000_0000;
        else if (rd || m_pend) begin
            e.ctl    = 8'b1111_1110;
            do_flush = 1'b1;
        end
        else if (ls)          e.ctl = 8'b0011_1010;
        else if (!im)         e.ctl = 8'b0111_1100;
        else                  e.ctl = 8'b1111_1000;
        e.scnt = rst ? 0 : m_scnt;
        e.fcnt = rst ? 0 : m_fcnt;
        e.tag  = tag;
        sb.push_back(e);

        @(negedge clk);
        g = sb.pop_front();
        check_val({g.tag, "_ctl"}, {24'd0, en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, mem_err}, {24'd0, g.ctl});
        check_val({g.tag, "_stall_cnt"}, {28'd0, stall_cnt}, g.scnt);
        check_val({g.tag, "_flush_cnt"}, {28'd0, flush_cnt}, g.fcnt);

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!e.ctl[7]) m_scnt = sat_inc(m_scnt);
            if (do_flush)  m_fcnt = sat_inc(m_fcnt);
            if (!m_err) begin
                if (dw) begin
                    m_run++;
                    if (rd) m_pend = 1'b1;
                    if (m_run == MEM_TIMEOUT) m_err = 1'b1;
                end else begin
                    m_run = 0;
                    if (do_flush) m_pend = 1'b0;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        ld_stall   = 1'b0;
        redirect   = 1'b0;
        imem_ready = 1'b1;
        dmem_req_M = 1'b0;
        dmem_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cycle("in_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("ld_stall", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("after_ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("imem_miss", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // dmem wait with redirect in the middle, then completion
        cycle("dw_a1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("dw_a2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("dw_a3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("dw_a_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle("dw_a_after", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        cycle("redir_over_ld", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("dmem_hit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // two redirects while frozen collapse into one flush
        cycle("dw_b1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("dw_b2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("dw_b_rel", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("dw_b_after", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // request dropped mid-wait must not hang
        cycle("dw_c1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("dw_c2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("dw_c_drop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // wait of MEM_TIMEOUT-1 cycles is still legal
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) cycle("dw_d", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("dw_d_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 14; i++) cycle("stall_sat", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle("flush_sat", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // timeout into ERR, then frozen regardless of inputs
        for (int i = 0; i < MEM_TIMEOUT; i++) cycle("timeout", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("err_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("err_redir", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("err_hit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        rst = 1'b1;
        cycle("err_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cycle("recover", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("recover_ld", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // async reset mid-DWAIT with a pending redirect
        cycle("dw_e1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("dw_e2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_ctl", {24'd0, en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, mem_err}, 32'd0);
        check_val("async_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        check_val("async_rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        dmem_req_M = 1'b0;
        cycle("post_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("post_rst2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        if (sb.size() != 0) check_val("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
